// File: rtl/pipe_mag_comp_pkg.sv
// Shared definitions for the pipelined magnitude comparator.
//   cmp_res_t    : per-stage compare state (EQ means "not yet decided")
//   stages_f     : number of pipeline stages for a WIDTH/SLICE pair
//   rem_bits_f   : operand bits still to be compared after stage k
//   rem_off_f    : offset of stage k's leftover bits in the packed leftover bus
//   rem_total_f  : total leftover bits held across all stages
package cmp_pkg;

  typedef enum logic [1:0] {
    CMP_EQ = 2'd0,
    CMP_GT = 2'd1,
    CMP_LT = 2'd2
  } cmp_res_t;

  function automatic int stages_f(input int width, input int slice);
    return width / slice;
  endfunction

  // Stage k has consumed slices 0..k, so the registers behind it only carry
  // the lower bits that are still to be compared.
  function automatic int rem_bits_f(input int width, input int slice, input int k);
    return width - (k + 1) * slice;
  endfunction

  function automatic int rem_off_f(input int width, input int slice, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) begin
      off += rem_bits_f(width, slice, j);
    end
    return off;
  endfunction

  function automatic int rem_total_f(input int width, input int slice);
    return rem_off_f(width, slice, stages_f(width, slice));
  endfunction

endpackage

// File: rtl/pipe_mag_comp_slice.sv
// Combinational unsigned compare of one SLICE-bit operand slice.
//   a_s, b_s : slice of operand A / B (already sign-adjusted upstream)
//   gt_s     : a_s > b_s
//   lt_s     : a_s < b_s
module cmp_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  output logic             gt_s,
  output logic             lt_s
);

  assign gt_s = (a_s > b_s);
  assign lt_s = (a_s < b_s);

endmodule

// File: rtl/pipe_mag_comp.sv
// Pipelined WIDTH-bit magnitude comparator, MSB slice first, one SLICE-bit
// slice per stage, with signed/unsigned mode and a valid/ready stream.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand pair handshake (a, b, is_signed)
//   out_valid/ out_ready: result handshake (gt, lt, eq one-hot when valid)
// The whole pipeline advances together: it stalls only when the result
// register is full and the consumer is not taking it.
module pipe_mag_comp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int STAGES  = stages_f(WIDTH, SLICE);
  localparam int REM_TOT = rem_total_f(WIDTH, SLICE);
  localparam int REM_W   = (REM_TOT > 0) ? REM_TOT : 1;
  localparam int RES_N   = (STAGES > 1) ? STAGES - 1 : 1;

  if (((WIDTH % SLICE) != 0) || (WIDTH < 2)) begin : g_param_err
    $error("pipe_mag_comp: WIDTH (%0d) must be >= 2 and a multiple of SLICE (%0d)",
           WIDTH, SLICE);
  end

  logic              adv;
  logic [STAGES-1:0] stage_valid;
  cmp_res_t          stage_res [RES_N];
  logic [REM_W-1:0]  rem_a;
  logic [REM_W-1:0]  rem_b;
  logic [WIDTH-1:0]  a_in;
  logic [WIDTH-1:0]  b_in;

  // Flipping the sign bits maps two's-complement order onto unsigned order,
  // so every stage can stay a plain unsigned slice compare.
  assign a_in = {a[WIDTH-1] ^ is_signed, a[WIDTH-2:0]};
  assign b_in = {b[WIDTH-1] ^ is_signed, b[WIDTH-2:0]};

  assign out_valid = stage_valid[STAGES-1];
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;

  if (REM_TOT == 0) begin : g_no_rem
    assign rem_a = '0;
    assign rem_b = '0;
  end

  if (STAGES == 1) begin : g_no_res
    assign stage_res[0] = CMP_EQ;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int REM   = rem_bits_f(WIDTH, SLICE, k);
    localparam int OFF   = rem_off_f(WIDTH, SLICE, k);
    localparam int P_REM = (k > 0) ? rem_bits_f(WIDTH, SLICE, k - 1) : 0;
    localparam int P_OFF = (k > 0) ? rem_off_f(WIDTH, SLICE, k - 1) : 0;

    logic             up_valid;
    cmp_res_t         up_res;
    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic             gt_s;
    logic             lt_s;
    cmp_res_t         res_new;
    logic             valid_q;
    logic             valid_d;

    if (k == 0) begin : g_first
      assign up_valid = in_valid;
      assign up_res   = CMP_EQ;
      assign sa       = a_in[WIDTH-1 -: SLICE];
      assign sb       = b_in[WIDTH-1 -: SLICE];
    end else begin : g_next
      assign up_valid = stage_valid[k-1];
      assign up_res   = stage_res[k-1];
      // Top slice of the previous stage's leftover bits is this stage's slice.
      assign sa       = rem_a[P_OFF + P_REM - 1 -: SLICE];
      assign sb       = rem_b[P_OFF + P_REM - 1 -: SLICE];
    end

    cmp_slice #(.SLICE(SLICE)) u_slice (
      .a_s  (sa),
      .b_s  (sb),
      .gt_s (gt_s),
      .lt_s (lt_s)
    );

    // A higher slice that already differed decides the result; lower slices
    // only matter while everything above them was equal.
    // NOTE: every always_comb output gets a default on entry so no path can
    // leave it unassigned, which would otherwise infer a latch.
    always_comb begin
      res_new = up_res;
      if (up_res == CMP_EQ) begin
        if (gt_s) begin
          res_new = CMP_GT;
        end else if (lt_s) begin
          res_new = CMP_LT;
        end
      end
    end

    always_comb begin
      valid_d = valid_q;
      if (adv) begin
        valid_d = up_valid;
      end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
    end

    assign stage_valid[k] = valid_q;

    if (k < STAGES - 1) begin : g_mid
      cmp_res_t       res_q;
      cmp_res_t       res_d;
      logic [REM-1:0] ra_q;
      logic [REM-1:0] ra_d;
      logic [REM-1:0] rb_q;
      logic [REM-1:0] rb_d;
      logic [REM-1:0] src_a;
      logic [REM-1:0] src_b;

      if (k == 0) begin : g_src_in
        assign src_a = a_in[REM-1:0];
        assign src_b = b_in[REM-1:0];
      end else begin : g_src_prev
        assign src_a = rem_a[P_OFF +: REM];
        assign src_b = rem_b[P_OFF +: REM];
      end

      // Data follows its valid: a bubble never overwrites the held pair.
      always_comb begin
        res_d = res_q;
        ra_d  = ra_q;
        rb_d  = rb_q;
        if (adv && up_valid) begin
          res_d = res_new;
          ra_d  = src_a;
          rb_d  = src_b;
        end
      end

      // NOTE: data registers are reset too; the cost is small and it keeps
      // the pipeline contents deterministic after reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res_q <= CMP_EQ;
          ra_q  <= '0;
          rb_q  <= '0;
        end else begin
          res_q <= res_d;
          ra_q  <= ra_d;
          rb_q  <= rb_d;
        end
      end

      assign stage_res[k]       = res_q;
      assign rem_a[OFF +: REM]  = ra_q;
      assign rem_b[OFF +: REM]  = rb_q;
    end else begin : g_last
      logic gt_q, gt_d;
      logic lt_q, lt_d;
      logic eq_q, eq_d;

      // Still undecided after the last slice means the operands are equal.
      always_comb begin
        gt_d = gt_q;
        lt_d = lt_q;
        eq_d = eq_q;
        if (adv && up_valid) begin
          gt_d = (res_new == CMP_GT);
          lt_d = (res_new == CMP_LT);
          eq_d = (res_new == CMP_EQ);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          gt_q <= 1'b0;
          lt_q <= 1'b0;
          eq_q <= 1'b0;
        end else begin
          gt_q <= gt_d;
          lt_q <= lt_d;
          eq_q <= eq_d;
        end
      end

      assign gt = gt_q;
      assign lt = lt_q;
      assign eq = eq_q;
    end
  end

endmodule
